// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue between fetch and decode.
package inst_fetch_queue_pkg;

    localparam int FETCH_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] instr
    );
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        e.adel  = (pc[1:0] != 2'b00);
        return e;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_mem.sv
// Entry storage: one write port, one asynchronous read port, no reset.
module fetch_queue_mem
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular fetch queue with wrap-bit pointers and keep-one flush support.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_instr,
    output logic                     push_ready,
    output logic                     pop_valid,
    output logic [31:0]              pop_pc,
    output logic [31:0]              pop_instr,
    output logic                     pop_adel,
    input  logic                     pop_ready,
    input  logic                     flush,
    input  logic                     flush_keep_one,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t         rd_ptr, wr_ptr;
    ptr_t         rd_nxt, wr_nxt;
    logic         full, empty;
    logic         do_push, do_pop, we;
    fetch_entry_t wdata, rdata;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign count      = wr_ptr - rd_ptr;
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop_ready && !empty;
    assign wdata      = make_entry(push_pc, push_instr);

    always_comb begin
        rd_nxt = rd_ptr + ptr_t'(do_pop);
        wr_nxt = wr_ptr + ptr_t'(do_push);
        we     = do_push;
        if (flush && !flush_keep_one) begin
            rd_nxt = wr_ptr;
            wr_nxt = wr_ptr;
            we     = 1'b0;
        end else if (flush) begin
            // The pop stays honoured; keep only the oldest survivor.
            if (wr_ptr != rd_nxt) begin
                wr_nxt = rd_nxt + ptr_t'(1);
                we     = 1'b0;
            end else if (do_push) begin
                wr_nxt = wr_ptr + ptr_t'(1);
                we     = 1'b1;
            end else begin
                wr_nxt = wr_ptr;
                we     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_nxt;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    assign pop_pc    = pop_valid ? rdata.pc    : 32'h0;
    assign pop_instr = pop_valid ? rdata.instr : 32'h0;
    assign pop_adel  = pop_valid ? rdata.adel  : 1'b0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench: directed scenarios plus random traffic against a queue model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    typedef struct {
        int   cnt;
        ent_t head;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic        push_ready;
    logic        pop_valid;
    logic [31:0] pop_pc;
    logic [31:0] pop_instr;
    logic        pop_adel;
    logic        pop_ready = 1'b0;
    logic        flush = 1'b0;
    logic        flush_keep_one = 1'b0;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    ent_t model[$];
    exp_t exp_q[$];
    ent_t pop_q[$];

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_instr     (push_instr),
        .push_ready     (push_ready),
        .pop_valid      (pop_valid),
        .pop_pc         (pop_pc),
        .pop_instr      (pop_instr),
        .pop_adel       (pop_adel),
        .pop_ready      (pop_ready),
        .flush          (flush),
        .flush_keep_one (flush_keep_one),
        .count          (count)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle of stimulus; the model advances by the queue's rules.
    task automatic step(input bit pv, input logic [31:0] pc, input bit pr,
                        input bit fl, input bit k1);
        exp_t e;
        ent_t en;
        int   n;
        @(posedge clk);
        #1;
        push_valid     = pv;
        push_pc        = pc;
        push_instr     = $urandom();
        pop_ready      = pr;
        flush          = fl;
        flush_keep_one = k1;
        n = model.size();
        e.cnt = n;
        e.head = '{pc: 32'h0, instr: 32'h0, adel: 1'b0};
        if (n > 0) e.head = model[0];
        exp_q.push_back(e);
        if (pr && n > 0) pop_q.push_back(model.pop_front());
        if (pv && n < DEPTH) begin
            en.pc    = pc;
            en.instr = push_instr;
            en.adel  = (pc % 4) != 0;
            model.push_back(en);
        end
        if (fl && !k1) model.delete();
        if (fl && k1) while (model.size() > 1) void'(model.pop_back());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        ent_t p;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("pop_valid", 32'(pop_valid), 32'(e.cnt != 0));
            chk("push_ready", 32'(push_ready), 32'(e.cnt != DEPTH));
            chk("pop_pc", pop_pc, e.head.pc);
            chk("pop_instr", pop_instr, e.head.instr);
            chk("pop_adel", 32'(pop_adel), 32'(e.head.adel));
            if (pop_valid && pop_ready) begin
                if (pop_q.size() == 0) begin
                    chk("unexpected_pop", 32'h1, 32'h0);
                end else begin
                    p = pop_q.pop_front();
                    chk("popped_pc", pop_pc, p.pc);
                    chk("popped_instr", pop_instr, p.instr);
                end
            end
        end
    end

    initial begin
        #3;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_pop_valid", 32'(pop_valid), 32'h0);
        chk("rst_push_ready", 32'(push_ready), 32'h1);
        chk("rst_pop_pc", pop_pc, 32'h0);
        #9 rst = 1'b0;

        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h110, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
        idle(1);

        step(1, 32'h500, 0, 0, 0);
        step(1, 32'h504, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 32'h508 + 32'(4 * i), 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        idle(1);

        for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h20C, 0, 1, 0);
        idle(1);

        for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 0);
        step(0, 32'h0, 1, 1, 1);
        idle(1);
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'h300, 0, 1, 1);
        idle(1);
        step(0, 32'h0, 1, 0, 0);

        step(1, 32'h0040_0002, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'h0040_0004, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        idle(1);

        step(1, 32'h600, 0, 0, 0);
        step(1, 32'h604, 0, 0, 0);
        idle(1);
        #6 rst = 1'b1;
        #1;
        chk("async_rst_pop_valid", 32'(pop_valid), 32'h0);
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_push_ready", 32'(push_ready), 32'h1);
        chk("async_rst_pop_pc", pop_pc, 32'h0);
        model.delete();
        #5 rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = $urandom();
            if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
            step($urandom_range(3) != 0, pc, $urandom_range(1) == 1,
                 $urandom_range(11) == 0, $urandom_range(1) == 1);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("pop_queue_drained", 32'(pop_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
